// File: rtl/hazard_ctrl_pkg.sv
// Shared control encodings and stage record types for the pipeline hazard unit.
package hazard_ctrl_pkg;

    typedef logic [4:0] reg_idx_t;

    // Operand source selection for the EX stage.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Shadow copy of the instruction sitting in EX.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        logic     load;
        reg_idx_t rs1;
        reg_idx_t rs2;
    } ex_stage_t;

    // Shadow copy of a later stage; only its register write matters.
    typedef struct packed {
        reg_idx_t rd;
        logic     we;
    } wr_stage_t;

    localparam ex_stage_t EX_BUBBLE = '0;
    localparam wr_stage_t WR_BUBBLE = '0;

    // Pick the youngest in-flight producer of rs; x0 is never forwarded.
    function automatic fwd_sel_e selectForward(input wr_stage_t memStage,
                                               input wr_stage_t wbStage,
                                               input reg_idx_t  rs);
        if (memStage.we && (memStage.rd != '0) && (memStage.rd == rs)) begin
            return FWD_MEM;
        end
        if (wbStage.we && (wbStage.rd != '0) && (wbStage.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID-stage hazard inputs and the resulting stall/flush/forward controls.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    reg_idx_t         id_rd;
    logic             id_we_reg;
    logic             id_load;
    logic             ex_pc_sel;

    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // The pipeline side drives instruction info and consumes the controls.
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we_reg, id_load, ex_pc_sel,
        input  stall_pc, stall_ifid, flush_ifid, flush_idex,
               fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );

    // The hazard unit side.
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_we_reg, id_load, ex_pc_sel,
        output stall_pc, stall_ifid, flush_ifid, flush_idex,
               fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one per cycle with inc high, holding once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch-redirect flush and operand forwarding control,
// driven by a shadow copy of the EX/MEM/WB destination registers.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    hazard_ctrl_if.slave  bus
);

    ex_stage_t r_ex;
    wr_stage_t r_mem;
    wr_stage_t r_wb;

    logic w_rs1Hit;
    logic w_rs2Hit;
    logic w_loadUse;
    logic w_redirect;
    logic w_stallPc;
    logic w_flushIdex;

    // Hazard detection and control outputs; a redirect discards the younger
    // instructions, so it overrides any stall they would have caused.
    always_comb begin
        w_rs1Hit    = bus.id_rs1_used && (bus.id_rs1 == r_ex.rd);
        w_rs2Hit    = bus.id_rs2_used && (bus.id_rs2 == r_ex.rd);
        w_loadUse   = r_ex.valid && r_ex.load && r_ex.we && (r_ex.rd != '0)
                      && (w_rs1Hit || w_rs2Hit);
        w_redirect  = r_ex.valid && bus.ex_pc_sel;

        w_stallPc      = 1'b0;
        w_flushIdex    = 1'b0;
        bus.stall_pc   = 1'b0;
        bus.stall_ifid = 1'b0;
        bus.flush_ifid = 1'b0;
        bus.flush_idex = 1'b0;

        if (w_redirect) begin
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
            w_flushIdex    = 1'b1;
        end else if (w_loadUse) begin
            bus.stall_pc   = 1'b1;
            bus.stall_ifid = 1'b1;
            bus.flush_idex = 1'b1;
            w_stallPc      = 1'b1;
            w_flushIdex    = 1'b1;
        end
    end

    // Operand source selects for the instruction currently in EX.
    always_comb begin
        bus.fwd_rs1_sel = selectForward(r_mem, r_wb, r_ex.rs1);
        bus.fwd_rs2_sel = selectForward(r_mem, r_wb, r_ex.rs2);
    end

    // Advance the shadow pipeline; a flushed ID/EX slot enters EX as a bubble.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_ex  <= EX_BUBBLE;
            r_mem <= WR_BUBBLE;
            r_wb  <= WR_BUBBLE;
        end else begin
            r_mem <= '{rd: r_ex.rd, we: r_ex.we};
            r_wb  <= r_mem;
            if (w_flushIdex) begin
                r_ex <= EX_BUBBLE;
            end else begin
                r_ex <= '{valid: 1'b1,
                          rd:    bus.id_rd,
                          we:    bus.id_we_reg,
                          load:  bus.id_load,
                          rs1:   bus.id_rs1,
                          rs2:   bus.id_rs2};
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .inc   (w_stallPc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .inc   (w_redirect),
        .count (bus.flush_cnt)
    );

endmodule
